level_decoder_fsm: RTL and testbench
====================================

Name: level_decoder_fsm

Overview:
- Sequencer for a bubble-level display.
- Drives a generic byte-oriented I2C master core to talk to an MPU-6050-class accelerometer at 7-bit address 0x68.
- Wakes the sensor once by writing 0x00 to register 0x6B, then reads register 0x3D (one axis high byte) in a continuous loop.
- Each signed reading is decoded to a one-hot position on a 9-LED bar; any bus error latches an error LED until reset.

Parameters:
- STEP_SHIFT, 1: tilt quantisation; one LED step = 2^STEP_SHIFT counts of the signed sample.
- READ_DELAY_CYCLES, 16: idle cycles between reads; used only when LEVEL_FSM_READ_DELAY_EN is defined.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- i2c_busy_i  in  1  I2C core busy
- i2c_rxak_i  in  1  0 = slave acknowledged
- i2c_arb_lost_i  in  1  arbitration lost
- i2c_write_done_i  in  1  write data accepted by slave
- i2c_data_out_valid_i  in  1  read data valid
- i2c_data_out_i  in  8  read data byte
- i2c_write_o  out  1  one-cycle write strobe
- i2c_read_o  out  1  one-cycle read strobe
- i2c_slave_addr_o  out  8  {7-bit addr, 1'b0}
- i2c_din_o  out  8  write data byte
- i2c_command_byte_o  out  8  register address
- i2c_num_bytes_o  out  8  bytes incl. command byte
- error_led_o  out  1  sticky error
- led_o  out  9  one-hot level indicator

Behaviour:
- Interface: one clock (clk_i); reset_i is synchronous and active-high.
- All outputs are registered.
- Reset (reset_i high at a rising edge, including mid-transfer):
  - every output is 0 (addr, cmd, din, num_bytes, strobes, error_led_o, led_o);
  - state returns to W_IDLE.
- States and transitions:
  - W_IDLE: wait for i2c_busy_i=0 → W_SETUP.
  - W_SETUP: drive addr=0xD0, cmd=0x6B, din=0x00, num_bytes=2 → W_STROBE.
  - W_STROBE: i2c_write_o=1 for exactly one cycle → W_START.
  - W_START: wait for i2c_busy_i=1 (transfer accepted) → W_WAIT.
  - W_WAIT: wait for i2c_busy_i=0 and i2c_write_done_i=1 → W_CHECK.
  - W_CHECK: if arb_lost=1 or rxak=1 → ERROR, else → R_IDLE.
  - R_IDLE: wait for busy=0 → R_SETUP.
  - R_SETUP: drive addr=0xD0, cmd=0x3D, din=0x00, num_bytes=2 → R_STROBE.
  - R_STROBE: i2c_read_o=1 for one cycle → R_START.
  - R_START: wait busy=1 → R_WAIT.
  - R_WAIT: wait busy=0 and data_out_valid=1 → R_CHECK.
  - R_CHECK: arb_lost=1 → ERROR. Otherwise latch i2c_data_out_i, update led_o next cycle, → R_IDLE (or R_DELAY when LEVEL_FSM_READ_DELAY_EN is defined). rxak is ignored on reads, because the master NACKs the last byte.
  - ERROR: error_led_o=1, both strobes 0, led_o holds its last value; exits only on reset.
- Strobes are never asserted outside the STROBE states.
- Address, command, din and num_bytes hold their last driven values between transactions.
- LED decode:
  - v = signed 8-bit sample; q = v divided by 2^STEP_SHIFT, truncated toward zero (magnitude shift, sign restored);
  - idx = 4 − q, clamped to the range 0..8; led_o = 1<<idx;
  - examples: v=0 → 0x010; v=0xF9 (−7) → q=−3, idx=7, led_o=128; v=+127 → 0x001; v=−128 → 0x100.
- Simultaneous events:
  - arb_lost together with a done/valid indication → ERROR wins;
  - a busy=0 level seen in START states is ignored; only the busy 0→1→0 sequence completes a transfer.

Optional Feature:
- Macro LEVEL_FSM_READ_DELAY_EN.
- Defined: after each successful read, an R_DELAY state counts READ_DELAY_CYCLES cycles with no strobes before R_IDLE; reset clears the counter.
- Undefined: R_CHECK goes directly to R_IDLE, so reads are back-to-back; the counter logic and parameter are unused.

Decomposition:
- Package level_fsm_pkg:
  - state enum;
  - constants MPU_ADDR7=7'h68, REG_PWR_MGMT_1=8'h6B, REG_ACCEL_H=8'h3D, PWR_WAKE=8'h00, NUM_BYTES=8'd2, LED_CENTER=4.
- Sub-module level_led_decode: combinational signed byte → 9-bit one-hot, parameterised by STEP_SHIFT.

Test Plan:
- Reset with busy=1 → all outputs 0, no strobe. Release busy → addr 0xD0, cmd 0x6B, din 0x00, num_bytes 2, then a single-cycle i2c_write_o.
- Write completes: busy 1 for 2 cycles, then busy=0, write_done=1, arb_lost=0, rxak=0 → error_led_o stays 0; cmd becomes 0x3D, then a single-cycle i2c_read_o.
- Read completes: busy pulse, then valid=1, data 0xF9, rxak=1, arb_lost=0 → led_o=128, error_led_o=0, next read strobe issued (loop).
- Read with arb_lost=1 on valid → error_led_o=1 and sticky; no further strobes until reset.
- After reset, write phase with write_done=1 and arb_lost=1 → error_led_o=1; no read strobe ever issued.
- Decode sweep (0x00, 0x7F, 0x80, 0x02, 0xFE) → 0x010, 0x001, 0x100, 0x008, 0x020.

Source files
------------

// File: rtl/level_decoder_fsm_pkg.sv
// Shared types and constants for the bubble-level sequencer.
package level_fsm_pkg;

    typedef enum logic [3:0] {
        W_IDLE,
        W_SETUP,
        W_STROBE,
        W_START,
        W_WAIT,
        W_CHECK,
        R_IDLE,
        R_SETUP,
        R_STROBE,
        R_START,
        R_WAIT,
        R_CHECK,
        R_DELAY,
        ERROR
    } state_e;

    localparam logic [6:0] MPU_ADDR7      = 7'h68;
    localparam logic [7:0] REG_PWR_MGMT_1 = 8'h6B;
    localparam logic [7:0] REG_ACCEL_H    = 8'h3D;
    localparam logic [7:0] PWR_WAKE       = 8'h00;
    localparam logic [7:0] NUM_BYTES      = 8'd2;
    localparam int         LED_CENTER     = 4;
    localparam int         LED_W          = 9;

endpackage

// File: rtl/level_decoder_fsm_if.sv
// Control/status bundle between the sequencer (master) and the byte-oriented I2C core (slave).
interface level_i2c_if;

    logic       busy;
    logic       rxak;
    logic       arb_lost;
    logic       write_done;
    logic       data_out_valid;
    logic [7:0] data_out;
    logic       write;
    logic       read;
    logic [7:0] slave_addr;
    logic [7:0] din;
    logic [7:0] command_byte;
    logic [7:0] num_bytes;

    modport master (
        input  busy, rxak, arb_lost, write_done, data_out_valid, data_out,
        output write, read, slave_addr, din, command_byte, num_bytes
    );

    modport slave (
        output busy, rxak, arb_lost, write_done, data_out_valid, data_out,
        input  write, read, slave_addr, din, command_byte, num_bytes
    );

endinterface

// File: rtl/level_decoder_fsm_led_decode.sv
// Signed accelerometer byte to one-hot bar position; one LED step = 2^STEP_SHIFT counts.
module level_led_decode
    import level_fsm_pkg::*;
#(
    parameter int STEP_SHIFT = 1
) (
    input  logic [7:0]       sample_i,
    output logic [LED_W-1:0] led_o
);

    localparam logic signed [9:0] CENTER_S = 10'(LED_CENTER);

    logic [7:0]        mag;
    logic [7:0]        mag_sh;
    logic signed [9:0] q;
    logic signed [9:0] idx;

    // Shift the magnitude, not the two's-complement value, so rounding is toward zero.
    always_comb begin
        mag    = sample_i[7] ? (8'd0 - sample_i) : sample_i;
        mag_sh = mag >> STEP_SHIFT;
        q      = sample_i[7] ? -$signed({2'b00, mag_sh}) : $signed({2'b00, mag_sh});
        idx    = CENTER_S - q;
        led_o  = '0;
        if (idx < 10'sd0) begin
            led_o[0] = 1'b1;
        end else if (idx > 10'sd8) begin
            led_o[LED_W-1] = 1'b1;
        end else begin
            led_o[idx[3:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/level_decoder_fsm.sv
// Wakes the accelerometer once, then polls one axis and drives the 9-LED level bar.
// Optional LEVEL_FSM_READ_DELAY_EN inserts READ_DELAY_CYCLES idle cycles between reads.
module level_decoder_fsm
    import level_fsm_pkg::*;
#(
    parameter int STEP_SHIFT = 1
`ifdef LEVEL_FSM_READ_DELAY_EN
  , parameter int READ_DELAY_CYCLES = 16
`endif
) (
    input  logic             clk_i,
    input  logic             reset_i,
    level_i2c_if.master      i2c,
    output logic             error_led_o,
    output logic [LED_W-1:0] led_o
);

    // state    | meaning
    // W_IDLE   | wait for core idle before the wake-up write
    // W_SETUP  | present address/command/data for PWR_MGMT_1
    // W_STROBE | one-cycle write strobe
    // W_START  | wait for core to go busy
    // W_WAIT   | wait for busy low with write done
    // W_CHECK  | judge latched arb-lost / NACK
    // R_IDLE   | wait for core idle before a read
    // R_SETUP  | present address/command for ACCEL high byte
    // R_STROBE | one-cycle read strobe
    // R_START  | wait for core to go busy
    // R_WAIT   | wait for busy low with data valid
    // R_CHECK  | judge latched arb-lost, update LEDs
    // R_DELAY  | optional inter-read gap
    // ERROR    | sticky fault, left only by reset

    state_e           state_q, state_d;
    logic             write_q, write_d, read_q, read_d, err_q, err_d;
    logic             arb_q, arb_d, rxak_q, rxak_d;
    logic [7:0]       addr_q, addr_d, cmd_q, cmd_d, din_q, din_d, nb_q, nb_d;
    logic [7:0]       sample_q, sample_d;
    logic [LED_W-1:0] led_q, led_d, led_dec;
`ifdef LEVEL_FSM_READ_DELAY_EN
    logic [15:0]      dly_q, dly_d;
`endif

    level_led_decode #(.STEP_SHIFT(STEP_SHIFT)) u_led_decode (
        .sample_i (sample_q),
        .led_o    (led_dec)
    );

    // Status and data are captured as the transfer completes, so CHECK does not depend on the core holding them.
    always_comb begin
        state_d  = state_q;
        arb_d    = arb_q;
        rxak_d   = rxak_q;
        sample_d = sample_q;
`ifdef LEVEL_FSM_READ_DELAY_EN
        dly_d    = dly_q;
`endif
        unique case (state_q)
            W_IDLE:   if (!i2c.busy) state_d = W_SETUP;
            W_SETUP:  state_d = W_STROBE;
            W_STROBE: state_d = W_START;
            W_START:  if (i2c.busy) state_d = W_WAIT;
            W_WAIT: begin
                if (!i2c.busy && i2c.write_done) begin
                    state_d = W_CHECK;
                    arb_d   = i2c.arb_lost;
                    rxak_d  = i2c.rxak;
                end
            end
            W_CHECK:  state_d = (arb_q || rxak_q) ? ERROR : R_IDLE;
            R_IDLE:   if (!i2c.busy) state_d = R_SETUP;
            R_SETUP:  state_d = R_STROBE;
            R_STROBE: state_d = R_START;
            R_START:  if (i2c.busy) state_d = R_WAIT;
            R_WAIT: begin
                if (!i2c.busy && i2c.data_out_valid) begin
                    state_d  = R_CHECK;
                    arb_d    = i2c.arb_lost;
                    sample_d = i2c.data_out;
                end
            end
            R_CHECK: begin
                if (arb_q) begin
                    state_d = ERROR;
                end else begin
`ifdef LEVEL_FSM_READ_DELAY_EN
                    state_d = R_DELAY;
                    dly_d   = 16'(READ_DELAY_CYCLES - 1);
`else
                    state_d = R_IDLE;
`endif
                end
            end
            R_DELAY: begin
`ifdef LEVEL_FSM_READ_DELAY_EN
                if (dly_q == 16'd0) state_d = R_IDLE;
                else                dly_d   = dly_q - 16'd1;
`else
                state_d = R_IDLE;
`endif
            end
            ERROR:    state_d = ERROR;
            default:  state_d = W_IDLE;
        endcase

        // Registered outputs are derived from the next state so they line up with the state they describe.
        write_d = (state_d == W_STROBE);
        read_d  = (state_d == R_STROBE);
        err_d   = err_q | (state_d == ERROR);
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        din_d   = din_q;
        nb_d    = nb_q;
        if (state_d == W_SETUP || state_d == R_SETUP) begin
            addr_d = {MPU_ADDR7, 1'b0};
            cmd_d  = (state_d == W_SETUP) ? REG_PWR_MGMT_1 : REG_ACCEL_H;
            din_d  = PWR_WAKE;
            nb_d   = NUM_BYTES;
        end
        led_d = (state_q == R_CHECK && !arb_q) ? led_dec : led_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= W_IDLE;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            err_q    <= 1'b0;
            arb_q    <= 1'b0;
            rxak_q   <= 1'b0;
            addr_q   <= '0;
            cmd_q    <= '0;
            din_q    <= '0;
            nb_q     <= '0;
            sample_q <= '0;
            led_q    <= '0;
`ifdef LEVEL_FSM_READ_DELAY_EN
            dly_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            read_q   <= read_d;
            err_q    <= err_d;
            arb_q    <= arb_d;
            rxak_q   <= rxak_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            din_q    <= din_d;
            nb_q     <= nb_d;
            sample_q <= sample_d;
            led_q    <= led_d;
`ifdef LEVEL_FSM_READ_DELAY_EN
            dly_q    <= dly_d;
`endif
        end
    end

    assign i2c.write        = write_q;
    assign i2c.read         = read_q;
    assign i2c.slave_addr   = addr_q;
    assign i2c.command_byte = cmd_q;
    assign i2c.din          = din_q;
    assign i2c.num_bytes    = nb_q;
    assign error_led_o      = err_q;
    assign led_o            = led_q;

endmodule

// File: tb/tb_level_decoder_fsm.sv
// Scoreboard bench: an I2C core model answers strobes; a monitor checks each strobe against queued expectations.
module tb_level_decoder_fsm;
    import level_fsm_pkg::*;

    localparam int STEP_SHIFT = 1;

    typedef struct {
        bit         is_read;
        logic [7:0] cmd;
        logic [8:0] led;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       error_led;
    logic [8:0] led;
    logic [8:0] led_model = '0;
    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;

    level_i2c_if bus ();

    level_decoder_fsm #(.STEP_SHIFT(STEP_SHIFT)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .i2c         (bus.master),
        .error_led_o (error_led),
        .led_o       (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode straight from the arithmetic definition.
    function automatic logic [8:0] model_led(input logic [7:0] b);
        int v, q, idx;
        v = int'(b);
        if (v > 127) v = v - 256;
        q   = v / (1 << STEP_SHIFT);
        idx = LED_CENTER - q;
        if (idx < 0) idx = 0;
        if (idx > 8) idx = 8;
        return 9'(1 << idx);
    endfunction

    // Monitor: every strobe must match the oldest pending expectation.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.write || bus.read) begin
                if (prev) check("strobe_width", 32'(prev), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'({bus.write, bus.read}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", 32'({bus.write, bus.read}), e.is_read ? 32'd1 : 32'd2);
                    check("slave_addr", 32'(bus.slave_addr), 32'hD0);
                    check("command_byte", 32'(bus.command_byte), 32'(e.cmd));
                    check("din", 32'(bus.din), 32'h00);
                    check("num_bytes", 32'(bus.num_bytes), 32'd2);
                    check("led_at_strobe", 32'(led), 32'(e.led));
                    check("error_at_strobe", 32'(error_led), 32'd0);
                end
            end
            prev = bus.write || bus.read;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_status();
        bus.write_done     = 1'b0;
        bus.data_out_valid = 1'b0;
        bus.arb_lost       = 1'b0;
        bus.rxak           = 1'b0;
        bus.data_out       = 8'($urandom);
    endtask

    task automatic apply_reset(input bit busy_v);
        reset    = 1'b1;
        bus.busy = busy_v;
        clear_status();
        exp_q.delete();
        led_model = '0;
        repeat (3) @(negedge clk);
        check("rst_write", 32'(bus.write), 32'd0);
        check("rst_read", 32'(bus.read), 32'd0);
        check("rst_addr", 32'(bus.slave_addr), 32'd0);
        check("rst_cmd", 32'(bus.command_byte), 32'd0);
        check("rst_din", 32'(bus.din), 32'd0);
        check("rst_num_bytes", 32'(bus.num_bytes), 32'd0);
        check("rst_error", 32'(error_led), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.write || bus.read) begin
                ok = 1'b1;
                return;
            end
        end
        check("strobe_timeout", 32'd0, 32'd1);
    endtask

    // Core model: optional late busy (busy=0 in START must be ignored), busy pulse, then completion flags.
    task automatic xfer_begin(input bit is_read, input bit arb, input bit rxak,
                              input logic [7:0] data, output bit ok);
        wait_strobe(ok);
        if (!ok) return;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.busy = 1'b1;
        repeat (2 + $urandom_range(0, 2)) @(negedge clk);
        bus.busy     = 1'b0;
        bus.arb_lost = arb;
        bus.rxak     = rxak;
        bus.data_out = data;
        if (is_read) bus.data_out_valid = 1'b1;
        else         bus.write_done     = 1'b1;
    endtask

    task automatic xfer_end();
        repeat (2) @(negedge clk);
        clear_status();
    endtask

    task automatic do_write(input bit arb, input bit rxak);
        bit ok;
        xfer_begin(1'b0, arb, rxak, 8'($urandom), ok);
        if (ok && !arb && !rxak) exp_q.push_back('{1'b1, REG_ACCEL_H, led_model});
        xfer_end();
    endtask

    task automatic do_read(input logic [7:0] v, input bit rxak);
        bit ok;
        xfer_begin(1'b1, 1'b0, rxak, v, ok);
        if (ok) begin
            led_model = model_led(v);
            exp_q.push_back('{1'b1, REG_ACCEL_H, led_model});
        end
        xfer_end();
    endtask

    initial begin
        logic [7:0] sweep[5];
        bit         ok;
        sweep = '{8'h00, 8'h7F, 8'h80, 8'h02, 8'hFE};
        bus.busy = 1'b1;
        clear_status();

        // Reset with the core busy; nothing may start until busy drops.
        apply_reset(1'b1);
        repeat (6) @(negedge clk);
        check("busy_hold_addr", 32'(bus.slave_addr), 32'd0);
        exp_q.push_back('{1'b0, REG_PWR_MGMT_1, 9'h000});
        bus.busy = 1'b0;
        do_write(1'b0, 1'b0);
        check("write_ok_error", 32'(error_led), 32'd0);

        // Read loop: NACK on reads is ignored; sweep boundaries, then random samples.
        do_read(8'hF9, 1'b1);
        foreach (sweep[i]) do_read(sweep[i], 1'($urandom));
        for (int i = 0; i < 20; i++) do_read(8'($urandom), 1'($urandom));

        // Arbitration lost on a read: sticky error, LEDs hold, no more strobes.
        begin
            xfer_begin(1'b1, 1'b1, 1'b0, 8'h55, ok);
            xfer_end();
        end
        repeat (20) @(negedge clk);
        check("read_arb_error", 32'(error_led), 32'd1);
        check("read_arb_led_hold", 32'(led), 32'(led_model));
        repeat (10) @(negedge clk);
        check("read_arb_sticky", 32'(error_led), 32'd1);

        // Reset in the middle of a write transfer.
        apply_reset(1'b0);
        exp_q.push_back('{1'b0, REG_PWR_MGMT_1, 9'h000});
        wait_strobe(ok);
        bus.busy = 1'b1;
        @(negedge clk);
        apply_reset(1'b1);
        repeat (4) @(negedge clk);
        exp_q.push_back('{1'b0, REG_PWR_MGMT_1, 9'h000});
        bus.busy = 1'b0;

        // Write completes together with arbitration lost: error wins, no read ever issued.
        do_write(1'b1, 1'b0);
        repeat (30) @(negedge clk);
        check("write_arb_error", 32'(error_led), 32'd1);
        check("write_arb_led", 32'(led), 32'd0);

        // Write NACKed by the slave.
        apply_reset(1'b0);
        exp_q.push_back('{1'b0, REG_PWR_MGMT_1, 9'h000});
        do_write(1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("write_nack_error", 32'(error_led), 32'd1);

        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
